request_unit: RTL

//  Memory request sequencer directly downstream of the ALU: consumes the ALU result as a data address.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/req_timer.sv | 29 ++
 rtl/request_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory request sequencer: FSM state encoding and
// the word type / alignment mask used by the data-side request path.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        REQ_IDLE   = 2'd0,
        REQ_DATA   = 2'd1,
        REQ_HALTED = 2'd2
    } reqstate_t;

    localparam logic [1:0] REQ_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/req_timer.sv
// Data-phase watchdog: counts enabled cycles from a clear and flags when the
// count reaches LIMIT. Only instantiated when REQ_TIMEOUT_EN is defined.
module req_timer #(
    parameter int LIMIT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != CW'(LIMIT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == CW'(LIMIT));

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer behind the ALU: issues one dREN/dWEN per load/store,
// gates PC advance on dhit, drops misaligned ops and latches HALT.
// Optional data-phase timeout is built when REQ_TIMEOUT_EN is defined.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dmemren_in,
    input  logic              dmemwen_in,
    input  logic              halt_in,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              imemREN,
    output logic              dREN,
    output logic              dWEN,
    output logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] dstore,
    output logic              pc_en,
    output logic              misalign,
    output logic              timeout_err,
    output logic              halted
);

    reqstate_t         state_reg, state_next;
    logic              dren_reg, dwen_reg;
    logic [ADDR_W-1:0] daddr_reg;
    logic [DATA_W-1:0] dstore_reg;
    logic              issue, retire, abort;
    logic              expired;
    logic              mem_op;
    logic              misaligned;

    assign mem_op     = dmemren_in | dmemwen_in;
    assign misaligned = (alu_result[1:0] & REQ_ALIGN_MASK) != 2'b00;

`ifdef REQ_TIMEOUT_EN
    logic timeout_err_reg;

    req_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (issue),
        .enable  ((state_reg == REQ_DATA) && !dhit),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            timeout_err_reg <= 1'b0;
        end else if (abort) begin
            timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    logic unused_cfg;
    assign unused_cfg  = TIMEOUT_CYCLES[0];
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= REQ_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Halt outranks a memory op on the same instruction; dhit only matters in DATA.
    always_comb begin
        state_next = state_reg;
        pc_en      = 1'b0;
        misalign   = 1'b0;
        issue      = 1'b0;
        retire     = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            REQ_IDLE: begin
                if (ihit) begin
                    if (halt_in) begin
                        state_next = REQ_HALTED;
                    end else if (!mem_op) begin
                        pc_en = 1'b1;
                    end else if (misaligned) begin
                        misalign = 1'b1;
                        pc_en    = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        state_next = REQ_DATA;
                    end
                end
            end
            REQ_DATA: begin
                if (dhit) begin
                    pc_en      = 1'b1;
                    retire     = 1'b1;
                    state_next = REQ_IDLE;
                end else if (expired) begin
                    pc_en      = 1'b1;
                    abort      = 1'b1;
                    state_next = REQ_IDLE;
                end
            end
            default: begin
                state_next = REQ_HALTED;
            end
        endcase
    end

    // Store wins when both load and store are decoded.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dren_reg   <= 1'b0;
            dwen_reg   <= 1'b0;
            daddr_reg  <= '0;
            dstore_reg <= '0;
        end else if (issue) begin
            dren_reg   <= ~dmemwen_in;
            dwen_reg   <= dmemwen_in;
            daddr_reg  <= alu_result;
            dstore_reg <= store_data;
        end else if (retire || abort) begin
            dren_reg   <= 1'b0;
            dwen_reg   <= 1'b0;
        end
    end

    assign imemREN = (state_reg == REQ_IDLE);
    assign halted  = (state_reg == REQ_HALTED);
    assign dREN    = dren_reg;
    assign dWEN    = dwen_reg;
    assign daddr   = daddr_reg;
    assign dstore  = dstore_reg;

endmodule
